// File: rtl/ram_port_arbiter.sv
// Round-robin arbiter sharing one single-port RAM between requesters A and B.
// Issues one access per cycle and returns registered read data with a valid strobe.
module ram_port_arbiter #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_gnt,
  output logic              a_rvalid,
  output logic [DATA_W-1:0] a_rdata,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_gnt,
  output logic              b_rvalid,
  output logic [DATA_W-1:0] b_rdata,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  input  logic [DATA_W-1:0] ram_dout
);

  logic last_b;

  // Grants are gated by rst_n so nothing reaches the RAM while in reset
  always_comb begin
    a_gnt = 1'b0;
    b_gnt = 1'b0;
    if (rst_n) begin
      if (a_req && (!b_req || last_b)) begin
        a_gnt = 1'b1;
      end else if (b_req) begin
        b_gnt = 1'b1;
      end
    end
  end

  always_comb begin
    ram_we   = 1'b0;
    ram_addr = a_addr;
    ram_din  = a_wdata;
    if (a_gnt) begin
      ram_we = a_we;
    end else if (b_gnt) begin
      ram_we   = b_we;
      ram_addr = b_addr;
      ram_din  = b_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_b   <= 1'b1;
      a_rvalid <= 1'b0;
      b_rvalid <= 1'b0;
      a_rdata  <= '0;
      b_rdata  <= '0;
    end else begin
      if (a_gnt) begin
        last_b <= 1'b0;
      end else if (b_gnt) begin
        last_b <= 1'b1;
      end
      a_rvalid <= a_gnt && !a_we;
      b_rvalid <= b_gnt && !b_we;
      if (a_gnt && !a_we) begin
        a_rdata <= ram_dout;
      end
      if (b_gnt && !b_we) begin
        b_rdata <= ram_dout;
      end
    end
  end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Self-checking bench for ram_port_arbiter: behavioural RAM, reference arbiter
// model and per-requester read-data queues filled at grant time.
module tb_ram_port_arbiter;

  localparam int AW = 10;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          a_req, a_we, b_req, b_we;
  logic [AW-1:0] a_addr, b_addr;
  logic [DW-1:0] a_wdata, b_wdata;
  logic          a_gnt, b_gnt, a_rvalid, b_rvalid;
  logic [DW-1:0] a_rdata, b_rdata;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_din, ram_dout;

  logic [DW-1:0] mem [0:(1<<AW)-1];

  int tests = 0;
  int failures = 0;

  logic          m_last_b;
  logic [DW-1:0] exp_mem [int];
  logic [DW-1:0] qa [$];
  logic [DW-1:0] qb [$];
  logic [DW-1:0] a_hold, b_hold;
  logic          ga, gb;

  always #5 clk = ~clk;

  ram_port_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout)
  );

  // Single-port RAM: synchronous write, asynchronous read
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_din;
  end
  assign ram_dout = mem[ram_addr];

  task automatic checkOutput(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] expected);
    tests++;
    if (got !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, got, expected);
    end
  endtask

  function automatic logic [DW-1:0] expRead(input logic [AW-1:0] addr);
    if (exp_mem.exists(int'(addr))) return exp_mem[int'(addr)];
    return '0;
  endfunction

  task automatic modelReset();
    m_last_b = 1'b1;
    qa.delete();
    qb.delete();
    a_hold = '0;
    b_hold = '0;
  endtask

  // One clock cycle: drive, check grant and RAM pins, then check read return
  task automatic applyStimulus(
    input logic ar, input logic aw, input logic [AW-1:0] aa, input logic [DW-1:0] ad,
    input logic br, input logic bw, input logic [AW-1:0] ba, input logic [DW-1:0] bd,
    output logic g_a, output logic g_b);
    logic rv_a, rv_b;
    logic          e_we;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_din;
    a_req = ar; a_we = aw; a_addr = aa; a_wdata = ad;
    b_req = br; b_we = bw; b_addr = ba; b_wdata = bd;
    #1;
    g_a = ar && (!br || m_last_b);
    g_b = br && (!ar || !m_last_b);
    e_we   = g_a ? aw : (g_b ? bw : 1'b0);
    e_addr = g_b ? ba : aa;
    e_din  = g_b ? bd : ad;
    checkOutput("a_gnt", DW'(a_gnt), DW'(g_a));
    checkOutput("b_gnt", DW'(b_gnt), DW'(g_b));
    checkOutput("ram_we", DW'(ram_we), DW'(e_we));
    checkOutput("ram_addr", DW'(ram_addr), DW'(e_addr));
    checkOutput("ram_din", ram_din, e_din);
    if (g_a) begin
      m_last_b = 1'b0;
      if (aw) exp_mem[int'(aa)] = ad;
      else qa.push_back(expRead(aa));
    end
    if (g_b) begin
      m_last_b = 1'b1;
      if (bw) exp_mem[int'(ba)] = bd;
      else qb.push_back(expRead(ba));
    end
    rv_a = g_a && !aw;
    rv_b = g_b && !bw;
    @(posedge clk);
    #1;
    checkOutput("a_rvalid", DW'(a_rvalid), DW'(rv_a));
    checkOutput("b_rvalid", DW'(b_rvalid), DW'(rv_b));
    if (rv_a) a_hold = qa.pop_front();
    if (rv_b) b_hold = qb.pop_front();
    checkOutput("a_rdata", a_rdata, a_hold);
    checkOutput("b_rdata", b_rdata, b_hold);
  endtask

  // Hold each request until the model grants it, bounded by a cycle budget
  task automatic runUntilGranted(
    input logic ar, input logic aw, input logic [AW-1:0] aa, input logic [DW-1:0] ad,
    input logic br, input logic bw, input logic [AW-1:0] ba, input logic [DW-1:0] bd);
    logic pa, pb;
    int n;
    pa = ar; pb = br; n = 0;
    while ((pa || pb) && n < 4) begin
      applyStimulus(pa, aw, aa, ad, pb, bw, ba, bd, ga, gb);
      if (ga) pa = 1'b0;
      if (gb) pb = 1'b0;
      n++;
    end
    if (pa || pb) checkOutput("grant_timeout", 32'd1, 32'd0);
  endtask

  task automatic idle();
    applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0, ga, gb);
  endtask

  initial begin
    for (int i = 0; i < (1<<AW); i++) mem[i] = '0;
    modelReset();

    rst_n = 1'b0;
    a_req = 1'b1; a_we = 1'b1; a_addr = 10'h005; a_wdata = 32'hFFFF_FFFF;
    b_req = 1'b1; b_we = 1'b1; b_addr = 10'h006; b_wdata = 32'hFFFF_FFFF;
    #1;
    checkOutput("rst_a_gnt", DW'(a_gnt), '0);
    checkOutput("rst_b_gnt", DW'(b_gnt), '0);
    checkOutput("rst_ram_we", DW'(ram_we), '0);
    checkOutput("rst_a_rvalid", DW'(a_rvalid), '0);
    checkOutput("rst_b_rvalid", DW'(b_rvalid), '0);
    checkOutput("rst_a_rdata", a_rdata, '0);
    checkOutput("rst_b_rdata", b_rdata, '0);
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_no_write", mem[10'h005], '0);
    a_req = 1'b0; b_req = 1'b0;
    rst_n = 1'b1;

    // First contention after reset goes to A
    runUntilGranted(1'b1, 1'b0, 10'h100, '0, 1'b1, 1'b0, 10'h101, '0);

    // A write then A read of 0x005
    runUntilGranted(1'b1, 1'b1, 10'h005, 32'hDEAD_BEEF, 1'b0, 1'b0, '0, '0);
    runUntilGranted(1'b1, 1'b0, 10'h005, '0, 1'b0, 1'b0, '0, '0);
    idle();

    // Preload, then six cycles of continuous contention
    runUntilGranted(1'b1, 1'b1, 10'h010, 32'h1111_1111, 1'b0, 1'b0, '0, '0);
    runUntilGranted(1'b0, 1'b0, '0, '0, 1'b1, 1'b1, 10'h3FF, 32'h2222_2222);
    for (int i = 0; i < 6; i++)
      applyStimulus(1'b1, 1'b0, 10'h010, '0, 1'b1, 1'b0, 10'h3FF, '0, ga, gb);
    idle();

    // Make A the most recent grant, then contend: B write wins, A reads new data
    runUntilGranted(1'b1, 1'b0, 10'h200, '0, 1'b0, 1'b0, '0, '0);
    runUntilGranted(1'b1, 1'b0, 10'h3FF, '0, 1'b1, 1'b1, 10'h3FF, 32'h0000_CAFE);
    idle();

    // Back-to-back reads of 0x000..0x003 with distinct contents
    for (int i = 0; i < 4; i++)
      runUntilGranted(1'b1, 1'b1, AW'(i), 32'hA500_0000 + DW'(i), 1'b0, 1'b0, '0, '0);
    for (int i = 0; i < 4; i++)
      applyStimulus(1'b1, 1'b0, AW'(i), '0, 1'b0, 1'b0, '0, '0, ga, gb);
    idle();

    // Dropped request has no side effect
    a_req = 1'b0; b_req = 1'b0;
    runUntilGranted(1'b1, 1'b0, 10'h010, '0, 1'b0, 1'b0, '0, '0);

    // Reset while a read result is being presented
    a_req = 1'b1;
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_a_rvalid", DW'(a_rvalid), '0);
    checkOutput("midrst_a_rdata", a_rdata, '0);
    checkOutput("midrst_a_gnt", DW'(a_gnt), '0);
    checkOutput("midrst_ram_we", DW'(ram_we), '0);
    modelReset();
    a_req = 1'b0; b_req = 1'b0;
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    runUntilGranted(1'b1, 1'b0, 10'h005, '0, 1'b0, 1'b0, '0, '0);
    checkOutput("ram_kept_005", a_rdata, 32'hDEAD_BEEF);
    idle();

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
